interval_timer_master: RTL and testbench

- Avalon-MM initiator that drives the 16-bit interval-timer slave without software involvement.
- On a start request it programs period_l, period_h and control, then services each timeout interrupt by clearing the status register and counting ticks.
- It stops the timer after a programmable tick count and captures counter snapshots on request.
- Sits between a hardware controller (e.g. the chess-motor step sequencer) and the timer's s1 slave port.

---
 rtl/interval_timer_master_if.sv | 21 ++
 rtl/interval_timer_master.sv | 219 +++++++++++++++++++++
 tb/tb_interval_timer_master.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_master_if.sv
// Avalon-MM bus between the interval-timer master and the timer's s1 slave.
// Command side is driven by the master; readdata/waitrequest come back.
interface interval_timer_master_if;
   logic [2:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic        m_read_n;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;
   logic        m_waitrequest;

   modport master (
      output m_address, m_chipselect, m_write_n, m_read_n, m_writedata,
      input  m_readdata, m_waitrequest
   );

   modport slave (
      input  m_address, m_chipselect, m_write_n, m_read_n, m_writedata,
      output m_readdata, m_waitrequest
   );
endinterface

// File: rtl/interval_timer_master.sv
// Hardware initiator for the 16-bit interval timer: programs it, services
// timeouts, counts ticks, auto-stops at a limit and captures snapshots.
module interval_timer_master #(
   parameter int READ_LATENCY = 1,
   parameter int IRQ_GUARD    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cfg_period,
   input  logic [31:0] cfg_tick_limit,
   input  logic        cfg_start,
   input  logic        cfg_stop,
   input  logic        snap_req,
   interval_timer_master_if.master bus,
   input  logic        irq,
   output logic        busy,
   output logic        running,
   output logic        tick,
   output logic [31:0] tick_count,
   output logic        done,
   output logic [31:0] snap_value,
   output logic        snap_valid
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN,
      S_CLR_TO, S_WR_SNAP, S_RD_L, S_RD_H, S_WR_STOP
   } state_t;

   localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY - 1);
   localparam logic [7:0] GUARD_INIT = 8'(IRQ_GUARD);

   state_t      state;
   logic [31:0] period_q;
   logic [31:0] limit_q;
   logic [15:0] snap_lo;
   logic        stop_pend;
   logic        snap_pend;
   logic [7:0]  guard;
   logic [7:0]  lat_cnt;
   logic        rd_wait;

   logic [2:0]  addr_q;
   logic [15:0] wdata_q;
   logic        cs_q;
   logic        write_n_q;
   logic        read_n_q;

   logic        cmd_state;
   logic        cmd_rd;
   logic [2:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        accept;
   logic        rd_done;
   logic [31:0] tick_next;

   assign bus.m_address    = addr_q;
   assign bus.m_writedata  = wdata_q;
   assign bus.m_chipselect = cs_q;
   assign bus.m_write_n    = write_n_q;
   assign bus.m_read_n     = read_n_q;

   assign accept    = cs_q && !bus.m_waitrequest;
   assign rd_done   = rd_wait && (lat_cnt == 8'd0);
   assign tick_next = tick_count + 32'd1;

   always_comb begin
      cmd_state = 1'b1;
      cmd_rd    = 1'b0;
      cmd_addr  = 3'd0;
      cmd_data  = 16'h0000;
      unique case (state)
         S_WR_PL:   begin cmd_addr = 3'd2; cmd_data = period_q[15:0];  end
         S_WR_PH:   begin cmd_addr = 3'd3; cmd_data = period_q[31:16]; end
         S_WR_CTRL: begin cmd_addr = 3'd1; cmd_data = 16'h0007;        end
         S_CLR_TO:  begin cmd_addr = 3'd0; cmd_data = 16'h0000;        end
         S_WR_SNAP: begin cmd_addr = 3'd4; cmd_data = 16'h0000;        end
         S_RD_L:    begin cmd_addr = 3'd4; cmd_rd = 1'b1;              end
         S_RD_H:    begin cmd_addr = 3'd5; cmd_rd = 1'b1;              end
         S_WR_STOP: begin cmd_addr = 3'd1; cmd_data = 16'h0008;        end
         default:   cmd_state = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         period_q   <= '0;
         limit_q    <= '0;
         snap_lo    <= '0;
         stop_pend  <= 1'b0;
         snap_pend  <= 1'b0;
         guard      <= '0;
         lat_cnt    <= '0;
         rd_wait    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cs_q       <= 1'b0;
         write_n_q  <= 1'b1;
         read_n_q   <= 1'b1;
         busy       <= 1'b0;
         running    <= 1'b0;
         tick       <= 1'b0;
         tick_count <= '0;
         done       <= 1'b0;
         snap_value <= '0;
         snap_valid <= 1'b0;
      end else begin
         tick       <= 1'b0;
         done       <= 1'b0;
         snap_valid <= 1'b0;

         if (guard != 8'd0) guard <= guard - 8'd1;

         if (state != S_IDLE) begin
            if (cfg_stop) stop_pend <= 1'b1;
            if (snap_req) snap_pend <= 1'b1;
         end

         // one command per state: issue once, drop strobes on acceptance
         if (cmd_state && !cs_q && !rd_wait) begin
            cs_q      <= 1'b1;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_data;
            write_n_q <= cmd_rd;
            read_n_q  <= !cmd_rd;
         end
         if (accept) begin
            cs_q      <= 1'b0;
            write_n_q <= 1'b1;
            read_n_q  <= 1'b1;
         end

         if (accept && !read_n_q) begin
            rd_wait <= 1'b1;
            lat_cnt <= LAT_INIT;
         end else if (rd_wait && lat_cnt != 8'd0) begin
            lat_cnt <= lat_cnt - 8'd1;
         end

         unique case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  period_q   <= cfg_period;
                  limit_q    <= cfg_tick_limit;
                  tick_count <= '0;
                  busy       <= 1'b1;
                  state      <= S_WR_PL;
               end
            end
            S_WR_PL:
               if (accept) state <= S_WR_PH;
            S_WR_PH:
               if (accept) state <= S_WR_CTRL;
            S_WR_CTRL: begin
               if (accept) begin
                  running <= 1'b1;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (stop_pend) begin
                  stop_pend <= 1'b0;
                  snap_pend <= 1'b0;
                  state     <= S_WR_STOP;
               end else if (irq && guard == 8'd0) begin
                  state <= S_CLR_TO;
               end else if (snap_pend) begin
                  snap_pend <= snap_req;
                  state     <= S_WR_SNAP;
               end
            end
            S_CLR_TO: begin
               if (accept) begin
                  tick_count <= tick_next;
                  tick       <= 1'b1;
                  guard      <= GUARD_INIT;
                  if (limit_q != 32'd0 && tick_next == limit_q) begin
                     stop_pend <= 1'b0;
                     snap_pend <= 1'b0;
                     state     <= S_WR_STOP;
                  end else begin
                     state <= S_RUN;
                  end
               end
            end
            S_WR_SNAP:
               if (accept) state <= S_RD_L;
            S_RD_L: begin
               if (rd_done) begin
                  snap_lo <= bus.m_readdata;
                  rd_wait <= 1'b0;
                  state   <= S_RD_H;
               end
            end
            S_RD_H: begin
               if (rd_done) begin
                  snap_value <= {bus.m_readdata, snap_lo};
                  snap_valid <= 1'b1;
                  rd_wait    <= 1'b0;
                  state      <= S_RUN;
               end
            end
            S_WR_STOP: begin
               if (accept) begin
                  running   <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  stop_pend <= 1'b0;
                  snap_pend <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interval_timer_master.sv
// Bench for interval_timer_master: timer-slave model, bus log compared
// against an expected transaction list built from the register protocol.
module tb_interval_timer_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] cfg_period = '0;
   logic [31:0] cfg_tick_limit = '0;
   logic        cfg_start = 1'b0;
   logic        cfg_stop = 1'b0;
   logic        snap_req = 1'b0;
   logic        irq;
   logic        busy, running, tick, done, snap_valid;
   logic [31:0] tick_count, snap_value;

   interval_timer_master_if bus ();

   interval_timer_master dut (
      .clk            (clk),
      .reset          (reset),
      .cfg_period     (cfg_period),
      .cfg_tick_limit (cfg_tick_limit),
      .cfg_start      (cfg_start),
      .cfg_stop       (cfg_stop),
      .snap_req       (snap_req),
      .bus            (bus.master),
      .irq            (irq),
      .busy           (busy),
      .running        (running),
      .tick           (tick),
      .tick_count     (tick_count),
      .done           (done),
      .snap_value     (snap_value),
      .snap_valid     (snap_valid)
   );

   always #5 clk = ~clk;

   logic        force_stall = 1'b0;
   logic        rnd_en = 1'b0;
   logic        rnd_bit = 1'b0;
   logic        irq_raise = 1'b0;
   logic        irq_direct = 1'b0;
   logic        to_flag;
   logic [15:0] rdata;
   logic [15:0] snap_lo_src = '0, snap_hi_src = '0;
   logic [15:0] snap_lo, snap_hi;

   assign bus.m_waitrequest = force_stall | (rnd_en & rnd_bit);
   assign bus.m_readdata    = rdata;
   assign irq = to_flag | irq_direct;

   logic [19:0] log_q[$];
   logic [19:0] exp_q[$];

   int vectors = 0, miscompares = 0;
   int n_tick = 0, n_done = 0, n_snapv = 0, n_ctrl = 0, n_clr = 0;
   int stab_err = 0, gap_err = 0;

   logic        pv_stall = 1'b0, pv_acc = 1'b0;
   logic [2:0]  pv_addr;
   logic [15:0] pv_data;
   logic        pv_wn, pv_rn;
   logic        acc;

   always @(negedge clk) rnd_bit <= ($urandom_range(0, 2) == 0);

   // timer slave model plus bus protocol monitor
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         to_flag  <= 1'b0;
         rdata    <= '0;
         snap_lo  <= '0;
         snap_hi  <= '0;
         pv_stall = 1'b0;
         pv_acc   = 1'b0;
      end else begin
         if (pv_stall && !(bus.m_chipselect && bus.m_address == pv_addr &&
             bus.m_writedata == pv_data && bus.m_write_n == pv_wn &&
             bus.m_read_n == pv_rn))
            stab_err++;
         if (pv_acc && bus.m_chipselect) gap_err++;
         acc      = bus.m_chipselect && !bus.m_waitrequest;
         pv_stall = bus.m_chipselect && bus.m_waitrequest;
         pv_acc   = acc;
         pv_addr  = bus.m_address;
         pv_data  = bus.m_writedata;
         pv_wn    = bus.m_write_n;
         pv_rn    = bus.m_read_n;
         if (irq_raise) to_flag <= 1'b1;
         if (acc) begin
            if (!bus.m_write_n) begin
               log_q.push_back({1'b1, bus.m_address,
                  (bus.m_address == 3'd4) ? 16'h0000 : bus.m_writedata});
               if (bus.m_address == 3'd0) begin
                  to_flag <= 1'b0;
                  n_clr++;
               end
               if (bus.m_address == 3'd1 && bus.m_writedata == 16'h0007)
                  n_ctrl++;
               if (bus.m_address == 3'd4) begin
                  snap_lo <= snap_lo_src;
                  snap_hi <= snap_hi_src;
               end
            end else begin
               log_q.push_back({1'b0, bus.m_address, 16'h0000});
               rdata <= (bus.m_address == 3'd4) ? snap_lo :
                        (bus.m_address == 3'd5) ? snap_hi : 16'h0000;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (tick) n_tick++;
      if (done) n_done++;
      if (snap_valid) n_snapv++;
   end

   localparam int W_TICK = 0, W_DONE = 1, W_SNAPV = 2, W_CTRL = 3, W_CLR = 4;

   function automatic int cnt(input int w);
      case (w)
         W_TICK:  return n_tick;
         W_DONE:  return n_done;
         W_SNAPV: return n_snapv;
         W_CTRL:  return n_ctrl;
         default: return n_clr;
      endcase
   endfunction

   function automatic logic [19:0] wr(input logic [2:0] a, input logic [15:0] d);
      return {1'b1, a, d};
   endfunction

   function automatic logic [19:0] rd(input logic [2:0] a);
      return {1'b0, a, 16'h0000};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wait_for(input string tag, input int w, input int target);
      int t = 0;
      while (cnt(w) < target && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk(tag, (cnt(w) >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_bus(input string tag, input logic [2:0] a,
                           input logic is_rd);
      int t = 0;
      while (!(bus.m_chipselect && bus.m_address == a &&
               bus.m_read_n == !is_rd) && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk(tag, {31'd0, bus.m_chipselect && bus.m_address == a}, 32'd1);
   endtask

   task automatic check_bus(input string tag);
      int n;
      chk({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk({tag, "_txn"}, 32'(log_q[i]), 32'(exp_q[i]));
      log_q.delete();
      exp_q.delete();
   endtask

   task automatic push_cfg(input logic [31:0] p);
      exp_q.push_back(wr(3'd2, p[15:0]));
      exp_q.push_back(wr(3'd3, p[31:16]));
      exp_q.push_back(wr(3'd1, 16'h0007));
   endtask

   task automatic push_snap();
      exp_q.push_back(wr(3'd4, 16'h0000));
      exp_q.push_back(rd(3'd4));
      exp_q.push_back(rd(3'd5));
   endtask

   task automatic do_start(input logic [31:0] p, input logic [31:0] lim);
      cfg_period = p;
      cfg_tick_limit = lim;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic do_stop();
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
   endtask

   task automatic do_snap();
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
   endtask

   task automatic raise_irq();
      irq_raise = 1'b1;
      @(negedge clk);
      irq_raise = 1'b0;
   endtask

   initial begin
      int base, based;
      int model_ticks;
      logic [31:0] p;
      logic [15:0] lo, hi;

      repeat (3) @(negedge clk);
      chk("rst_cs", {31'd0, bus.m_chipselect}, 32'd0);
      chk("rst_write_n", {31'd0, bus.m_write_n}, 32'd1);
      chk("rst_read_n", {31'd0, bus.m_read_n}, 32'd1);
      chk("rst_addr", {29'd0, bus.m_address}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_running", {31'd0, running}, 32'd0);
      chk("rst_tick_count", tick_count, 32'd0);
      chk("rst_snap_value", snap_value, 32'd0);
      chk("rst_pulses", {29'd0, tick, done, snap_valid}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // programming sequence
      push_cfg(32'h005F5E0F);
      base = n_ctrl;
      do_start(32'h005F5E0F, 32'd0);
      wait_for("ctrl_write", W_CTRL, base + 1);
      chk("running_after_ctrl", {31'd0, running}, 32'd1);
      chk("busy_in_run", {31'd0, busy}, 32'd1);
      check_bus("cfg_seq");

      // first timeout, then guard window
      base = n_clr;
      raise_irq();
      wait_for("clr1", W_CLR, base + 1);
      exp_q.push_back(wr(3'd0, 16'h0000));
      chk("tick_pulse", {31'd0, tick}, 32'd1);
      chk("tick_count1", tick_count, 32'd1);
      irq_direct = 1'b1;
      @(negedge clk);
      irq_direct = 1'b0;
      @(negedge clk);
      chk("guard_ignore", tick_count, 32'd1);
      irq_direct = 1'b1;
      base = n_tick;
      @(negedge clk);
      irq_direct = 1'b0;
      wait_for("guard_expired_tick", W_TICK, base + 1);
      chk("tick_count2", tick_count, 32'd2);
      exp_q.push_back(wr(3'd0, 16'h0000));
      check_bus("guard_seq");
      model_ticks = 2;

      // directed snapshot
      snap_lo_src = 16'h1234;
      snap_hi_src = 16'h0056;
      base = n_snapv;
      push_snap();
      do_snap();
      wait_for("snap_done", W_SNAPV, base + 1);
      repeat (5) @(negedge clk);
      chk("snap_value", snap_value, 32'h00561234);
      chk("snap_valid_once", 32'(n_snapv - base), 32'd1);
      check_bus("snap_seq");

      // randomized ticks/snapshots under random stalls
      rnd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            base = n_tick;
            raise_irq();
            model_ticks++;
            exp_q.push_back(wr(3'd0, 16'h0000));
            wait_for("rnd_tick", W_TICK, base + 1);
            chk("rnd_tick_count", tick_count, 32'(model_ticks));
         end else begin
            lo = 16'($urandom);
            hi = 16'($urandom);
            snap_lo_src = lo;
            snap_hi_src = hi;
            base = n_snapv;
            push_snap();
            do_snap();
            wait_for("rnd_snap", W_SNAPV, base + 1);
            chk("rnd_snap_value", snap_value, {hi, lo});
         end
         check_bus("rnd_bus");
      end

      // explicit stop from RUN
      based = n_done;
      exp_q.push_back(wr(3'd1, 16'h0008));
      do_stop();
      wait_for("stop_done", W_DONE, based + 1);
      chk("stop_running", {31'd0, running}, 32'd0);
      chk("stop_busy", {31'd0, busy}, 32'd0);
      check_bus("stop_seq");

      // auto-stop at limit 3
      p = $urandom;
      push_cfg(p);
      base = n_ctrl;
      do_start(p, 32'd3);
      wait_for("lim_ctrl", W_CTRL, base + 1);
      based = n_done;
      for (int k = 0; k < 3; k++) begin
         base = n_tick;
         raise_irq();
         exp_q.push_back(wr(3'd0, 16'h0000));
         wait_for("lim_tick", W_TICK, base + 1);
      end
      exp_q.push_back(wr(3'd1, 16'h0008));
      wait_for("lim_done", W_DONE, based + 1);
      chk("lim_tick_count", tick_count, 32'd3);
      chk("lim_running", {31'd0, running}, 32'd0);
      chk("lim_busy", {31'd0, busy}, 32'd0);
      repeat (4) @(negedge clk);
      chk("lim_done_once", 32'(n_done - based), 32'd1);
      check_bus("lim_seq");

      // 4-cycle stall on period_h with a stop arriving meanwhile
      rnd_en = 1'b0;
      @(negedge clk);
      p = $urandom;
      push_cfg(p);
      exp_q.push_back(wr(3'd1, 16'h0008));
      based = n_done;
      do_start(p, 32'd0);
      wait_bus("ph_issue", 3'd3, 1'b0);
      force_stall = 1'b1;
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      repeat (3) @(negedge clk);
      force_stall = 1'b0;
      wait_for("stall_done", W_DONE, based + 1);
      check_bus("stall_seq");
      chk("stall_stable", 32'(stab_err), 32'd0);
      chk("strobe_gap", 32'(gap_err), 32'd0);
      chk("stall_ticks", tick_count, 32'd0);

      // reset in the middle of the low snapshot read
      p = $urandom;
      base = n_ctrl;
      do_start(p, 32'd0);
      wait_for("rst_ctrl", W_CTRL, base + 1);
      do_snap();
      wait_bus("rdl_issue", 3'd4, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_cs", {31'd0, bus.m_chipselect}, 32'd0);
      chk("mid_rst_write_n", {31'd0, bus.m_write_n}, 32'd1);
      chk("mid_rst_read_n", {31'd0, bus.m_read_n}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      log_q.delete();
      exp_q.delete();
      @(negedge clk);
      p = $urandom;
      push_cfg(p);
      base = n_ctrl;
      do_start(p, 32'd0);
      wait_for("restart_ctrl", W_CTRL, base + 1);
      chk("restart_running", {31'd0, running}, 32'd1);
      chk("restart_ticks", tick_count, 32'd0);
      check_bus("restart_seq");
      based = n_done;
      exp_q.push_back(wr(3'd1, 16'h0008));
      do_stop();
      wait_for("final_done", W_DONE, based + 1);
      check_bus("final_seq");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
